puf_eval_controller: RTL and testbench

//  Sequencer upstream and downstream of the PUF mapping stage. Accepts a challenge and PDL config from
//  the host-side handler, then runs NUM_EVALS reset/trigger/sample rounds on the PUF. Majority-votes each

---
 rtl/puf_eval_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_puf_eval_controller.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_eval_controller.sv
// -----------------------------------------------------------------------------
// puf_eval_controller
//
// Purpose:
//   Runs a PUF through NUM_EVALS reset/trigger/sample rounds for one challenge
//   and PDL configuration. Each response bit is majority-voted over the
//   rounds. The controller returns the voted response, its XOR-reduce, and a
//   per-bit mask of bits that did not agree across all rounds.
//
// Handshakes:
//   Both start_* and resp_* follow strict valid/ready semantics. A transfer
//   happens on a rising clk edge where valid and ready are both high. Once
//   resp_valid is raised, it and all resp_* values stay constant until that
//   transfer. start_ready is high only in IDLE, so at most one request is ever
//   in flight. A new start can be accepted no earlier than the cycle after the
//   resp transfer.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous, active-low; returns everything to IDLE
//   start_valid       request present
//   start_ready       request accepted when high together with start_valid
//   challenge_in      challenge, latched on the start transfer
//   pdl_config_in     PDL delay configuration, latched on the start transfer
//   abort             cancels a request in ARM/FIRE/SAMPLE (ignored in IDLE/DONE)
//   puf_reset         active-high clear to the PUF arbiters
//   puf_trigger       launch level to the PUF
//   puf_challenge     latched challenge, stable for the whole request
//   puf_pdl_config    latched configuration, stable for the whole request
//   puf_raw_response  raw PUF response, sampled once per round
//   resp_valid        voted result available (DONE)
//   resp_ready        consumer accepts the result
//   resp_data         majority-voted response
//   resp_xor          XOR-reduce of resp_data
//   resp_unstable     bit i set when bit i differed between rounds
//   busy              controller is not in IDLE
//   state_dbg         current FSM state encoding (debug observation)
//
// All outputs come straight from flops. No input has a combinational path to
// any output.
// -----------------------------------------------------------------------------
module puf_eval_controller #(
    parameter int CHALLENGE_WIDTH  = 32,
    parameter int PDL_CONFIG_WIDTH = 128,
    parameter int RESPONSE_WIDTH   = 6,
    parameter int NUM_EVALS        = 7,
    parameter int RESET_CYCLES     = 4,
    parameter int SETTLE_CYCLES    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [CHALLENGE_WIDTH-1:0]  challenge_in,
    input  logic [PDL_CONFIG_WIDTH-1:0] pdl_config_in,
    input  logic                        abort,
    output logic                        puf_reset,
    output logic                        puf_trigger,
    output logic [CHALLENGE_WIDTH-1:0]  puf_challenge,
    output logic [PDL_CONFIG_WIDTH-1:0] puf_pdl_config,
    input  logic [RESPONSE_WIDTH-1:0]   puf_raw_response,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [RESPONSE_WIDTH-1:0]   resp_data,
    output logic                        resp_xor,
    output logic [RESPONSE_WIDTH-1:0]   resp_unstable,
    output logic                        busy,
    output logic [2:0]                  state_dbg
);

    // -------------------------------------------------------------------------
    // Parameter legality
    // -------------------------------------------------------------------------
    generate
        if ((NUM_EVALS < 1) || (NUM_EVALS > 255) || ((NUM_EVALS % 2) == 0)) begin : g_bad_num_evals
            $error("puf_eval_controller: NUM_EVALS must be odd and within 1..255");
        end
        if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
            $error("puf_eval_controller: RESET_CYCLES must be at least 1");
        end
        if (SETTLE_CYCLES < 1) begin : g_bad_settle_cycles
            $error("puf_eval_controller: SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Widths
    // -------------------------------------------------------------------------
    // ones counters must be able to hold NUM_EVALS itself
    localparam int ONES_W    = $clog2(NUM_EVALS + 1);
    localparam int IDX_W     = (NUM_EVALS > 1) ? $clog2(NUM_EVALS) : 1;
    localparam int MAX_PHASE = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_FIRE   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      phase_cnt;
    logic [IDX_W-1:0]      round_idx;
    logic [ONES_W-1:0]     ones     [RESPONSE_WIDTH];
    logic [ONES_W-1:0]     ones_inc [RESPONSE_WIDTH];
    logic                  accept;
    logic                  sample_en;
    logic                  last_round;
    logic [RESPONSE_WIDTH-1:0] vote_data;
    logic [RESPONSE_WIDTH-1:0] vote_unstable;

    assign state_dbg  = state;
    assign last_round = (round_idx == IDX_W'(NUM_EVALS - 1));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        sample_en  = 1'b0;
        case (state)
            S_IDLE: begin
                // abort has no meaning here; a same-cycle start still goes ahead
                if (start_valid) begin
                    accept     = 1'b1;
                    state_next = S_ARM;
                end
            end
            S_ARM: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (phase_cnt == CNT_W'(RESET_CYCLES - 1)) begin
                    state_next = S_FIRE;
                end
            end
            S_FIRE: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (phase_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else begin
                    sample_en  = 1'b1;
                    state_next = last_round ? S_DONE : S_ARM;
                end
            end
            S_DONE: begin
                // resp_valid is high for the whole of DONE, so resp_ready alone completes the transfer
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Vote arithmetic on the counters as they will be after this sample
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < RESPONSE_WIDTH; i++) begin
            ones_inc[i] = ones[i];
            // saturate rather than wrap, even though NUM_EVALS samples cannot overflow
            if (puf_raw_response[i] && (ones[i] != ONES_W'(NUM_EVALS))) begin
                ones_inc[i] = ones[i] + ONES_W'(1);
            end
            vote_data[i]     = (ones_inc[i] > ONES_W'(NUM_EVALS / 2));
            vote_unstable[i] = (ones_inc[i] != '0) && (ones_inc[i] != ONES_W'(NUM_EVALS));
        end
    end

    // -------------------------------------------------------------------------
    // State, counters, latches and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            phase_cnt      <= '0;
            round_idx      <= '0;
            for (int i = 0; i < RESPONSE_WIDTH; i++) begin
                ones[i] <= '0;
            end
            start_ready    <= 1'b1;
            busy           <= 1'b0;
            puf_reset      <= 1'b1;
            puf_trigger    <= 1'b0;
            puf_challenge  <= '0;
            puf_pdl_config <= '0;
            resp_valid     <= 1'b0;
            resp_data      <= '0;
            resp_xor       <= 1'b0;
            resp_unstable  <= '0;
        end else begin
            state <= state_next;

            // Outputs are decoded from the state being entered so they line up
            // with that state while still coming from flops.
            start_ready <= (state_next == S_IDLE);
            busy        <= (state_next != S_IDLE);
            puf_reset   <= (state_next == S_IDLE) || (state_next == S_ARM) || (state_next == S_DONE);
            puf_trigger <= (state_next == S_FIRE) || (state_next == S_SAMPLE);
            resp_valid  <= (state_next == S_DONE);

            // Phase counter restarts on every state change, including SAMPLE->ARM
            if ((state_next == state) && ((state == S_ARM) || (state == S_FIRE))) begin
                phase_cnt <= phase_cnt + CNT_W'(1);
            end else begin
                phase_cnt <= '0;
            end

            if (accept) begin
                puf_challenge  <= challenge_in;
                puf_pdl_config <= pdl_config_in;
                round_idx      <= '0;
                for (int i = 0; i < RESPONSE_WIDTH; i++) begin
                    ones[i] <= '0;
                end
            end

            if (sample_en) begin
                for (int i = 0; i < RESPONSE_WIDTH; i++) begin
                    ones[i] <= ones_inc[i];
                end
                if (!last_round) begin
                    round_idx <= round_idx + IDX_W'(1);
                end
            end

            // Result is captured once, on the way into DONE, and held until consumed
            if ((state == S_SAMPLE) && (state_next == S_DONE)) begin
                resp_data     <= vote_data;
                resp_xor      <= ^vote_data;
                resp_unstable <= vote_unstable;
            end else if ((state == S_DONE) && (state_next == S_IDLE)) begin
                resp_data     <= '0;
                resp_xor      <= 1'b0;
                resp_unstable <= '0;
            end
        end
    end

endmodule

// File: tb/tb_puf_eval_controller.sv
`timescale 1ns/1ps
module tb_puf_eval_controller;

    localparam int CW  = 32;
    localparam int PW  = 128;
    localparam int RW  = 6;
    localparam int NE  = 7;
    localparam int RC  = 4;
    localparam int SC  = 16;
    localparam int LAT = NE * (RC + SC + 1);
    localparam int EW  = 2 * RW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- main DUT signals ----------------
    logic          start_valid;
    logic          start_ready;
    logic [CW-1:0] challenge_in;
    logic [PW-1:0] pdl_config_in;
    logic          abort;
    logic          puf_reset;
    logic          puf_trigger;
    logic [CW-1:0] puf_challenge;
    logic [PW-1:0] puf_pdl_config;
    logic [RW-1:0] puf_raw_response;
    logic          resp_valid;
    logic          resp_ready;
    logic [RW-1:0] resp_data;
    logic          resp_xor;
    logic [RW-1:0] resp_unstable;
    logic          busy;
    logic [2:0]    state_dbg;

    // ---------------- small DUT signals (N=1, R=1, S=1) ----------------
    logic          s_start_valid;
    logic          s_start_ready;
    logic          s_abort;
    logic          s_puf_reset;
    logic          s_puf_trigger;
    logic [CW-1:0] s_puf_challenge;
    logic [PW-1:0] s_puf_pdl_config;
    logic [RW-1:0] s_puf_raw_response;
    logic          s_resp_valid;
    logic          s_resp_ready;
    logic [RW-1:0] s_resp_data;
    logic          s_resp_xor;
    logic [RW-1:0] s_resp_unstable;
    logic          s_busy;
    logic [2:0]    s_state_dbg;

    puf_eval_controller #(
        .CHALLENGE_WIDTH(CW), .PDL_CONFIG_WIDTH(PW), .RESPONSE_WIDTH(RW),
        .NUM_EVALS(NE), .RESET_CYCLES(RC), .SETTLE_CYCLES(SC)
    ) u_dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .challenge_in(challenge_in), .pdl_config_in(pdl_config_in),
        .abort(abort),
        .puf_reset(puf_reset), .puf_trigger(puf_trigger),
        .puf_challenge(puf_challenge), .puf_pdl_config(puf_pdl_config),
        .puf_raw_response(puf_raw_response),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_xor(resp_xor), .resp_unstable(resp_unstable),
        .busy(busy), .state_dbg(state_dbg)
    );

    puf_eval_controller #(
        .CHALLENGE_WIDTH(CW), .PDL_CONFIG_WIDTH(PW), .RESPONSE_WIDTH(RW),
        .NUM_EVALS(1), .RESET_CYCLES(1), .SETTLE_CYCLES(1)
    ) u_small (
        .clk(clk), .reset(reset),
        .start_valid(s_start_valid), .start_ready(s_start_ready),
        .challenge_in(challenge_in), .pdl_config_in(pdl_config_in),
        .abort(s_abort),
        .puf_reset(s_puf_reset), .puf_trigger(s_puf_trigger),
        .puf_challenge(s_puf_challenge), .puf_pdl_config(s_puf_pdl_config),
        .puf_raw_response(s_puf_raw_response),
        .resp_valid(s_resp_valid), .resp_ready(s_resp_ready),
        .resp_data(s_resp_data), .resp_xor(s_resp_xor), .resp_unstable(s_resp_unstable),
        .busy(s_busy), .state_dbg(s_state_dbg)
    );

    // ---------------- PUF model: per-round response table ----------------
    logic [RW-1:0] pattern [8];
    logic [2:0]    round_idx = 3'd0;
    logic          trig_d = 1'b0;

    assign puf_raw_response = pattern[round_idx];

    // Round advances after each trigger falling edge; restarts on each accepted start
    always @(negedge clk) begin
        if (start_valid && start_ready) begin
            round_idx = 3'd0;
        end else if (trig_d && !puf_trigger) begin
            round_idx = round_idx + 3'd1;
        end
        trig_d = puf_trigger;
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] s_exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare on every resp transfer
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (resp_valid && resp_ready) begin
            check("resp_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("resp_data", resp_data, e[RW-1:0]);
                check("resp_unstable", resp_unstable, e[2*RW-1:RW]);
                check("resp_xor", resp_xor, e[2*RW]);
            end
        end
        if (s_resp_valid && s_resp_ready) begin
            check("s_resp_expected", s_exp_q.size() != 0, 1'b1);
            if (s_exp_q.size() != 0) begin
                e = s_exp_q.pop_front();
                check("s_resp_data", s_resp_data, e[RW-1:0]);
                check("s_resp_unstable", s_resp_unstable, e[2*RW-1:RW]);
                check("s_resp_xor", s_resp_xor, e[2*RW]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_const(input logic [RW-1:0] v);
        for (int i = 0; i < 8; i++) pattern[i] = v;
    endtask

    // Called just after a rising edge; returns just after the transfer edge
    task automatic issue(input logic [CW-1:0] c, input logic [PW-1:0] p);
        int n = 0;
        start_valid   = 1'b1;
        challenge_in  = c;
        pdl_config_in = p;
        while (!start_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("start_ready_wait", n < 1000, 1'b1);
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_resp(input int exp_lat, input string name);
        int n = 0;
        while (!resp_valid && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, n, exp_lat);
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        int seen;
        reset              = 1'b0;
        start_valid        = 1'b0;
        challenge_in       = '0;
        pdl_config_in      = '0;
        abort              = 1'b0;
        resp_ready         = 1'b1;
        s_start_valid      = 1'b0;
        s_abort            = 1'b0;
        s_resp_ready       = 1'b1;
        s_puf_raw_response = 6'b000111;
        set_const('0);

        repeat (3) @(posedge clk);
        #1;
        // reset values
        check("rst_start_ready", start_ready, 1'b1);
        check("rst_puf_reset", puf_reset, 1'b1);
        check("rst_puf_trigger", puf_trigger, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", state_dbg, 3'd0);
        check("rst_s_start_ready", s_start_ready, 1'b1);
        reset = 1'b1;
        step();

        // T1: constant 101100
        set_const(6'b101100);
        exp_q.push_back({1'b1, 6'b000000, 6'b101100});
        issue(32'hA5A5_0001, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978);
        challenge_in  = 32'hDEAD_BEEF;
        pdl_config_in = '1;
        check("t1_busy", busy, 1'b1);
        check("t1_start_ready_low", start_ready, 1'b0);
        check("t1_puf_reset_arm", puf_reset, 1'b1);
        check("t1_challenge_latched", puf_challenge, 32'hA5A5_0001);
        check("t1_config_latched", puf_pdl_config, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978);
        wait_resp(LAT, "t1_latency");
        check("t1_puf_reset_done", puf_reset, 1'b1);
        check("t1_puf_trigger_done", puf_trigger, 1'b0);
        step();
        check("t1_back_idle", start_ready, 1'b1);

        // T2: bit0 set in 4 of 7 rounds, bit1 in 3 of 7
        set_const('0);
        pattern[0] = 6'b000011;
        pattern[1] = 6'b000011;
        pattern[2] = 6'b000011;
        pattern[3] = 6'b000001;
        exp_q.push_back({1'b1, 6'b000011, 6'b000001});
        issue(32'h0000_0002, '0);
        wait_resp(LAT, "t2_latency");
        step();

        // T3: consumer stalls 20 cycles in DONE while a new start is offered
        set_const(6'b010011);
        resp_ready = 1'b0;
        exp_q.push_back({1'b1, 6'b000000, 6'b010011});
        issue(32'h3333_0001, '0);
        wait_resp(LAT, "t3_latency");
        start_valid  = 1'b1;
        challenge_in = 32'h3333_0002;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!resp_valid || resp_data !== 6'b010011 || start_ready || puf_challenge !== 32'h3333_0001)
                seen++;
        end
        check("t3_hold_stable", seen, 0);
        exp_q.push_back({1'b1, 6'b000000, 6'b010011});
        resp_ready = 1'b1;
        step();
        check("t3_ready_after_hs", start_ready, 1'b1);
        check("t3_valid_dropped", resp_valid, 1'b0);
        step();
        start_valid = 1'b0;
        check("t3_accepted_next", busy, 1'b1);
        check("t3_new_challenge", puf_challenge, 32'h3333_0002);
        wait_resp(LAT, "t3b_latency");
        step();

        // T4: abort in FIRE of the third round
        set_const('0);
        issue(32'h4444_0001, '0);
        repeat (51) step();
        check("t4_in_fire", puf_trigger, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_idle_busy", busy, 1'b0);
        check("t4_idle_ready", start_ready, 1'b1);
        check("t4_idle_trigger", puf_trigger, 1'b0);
        check("t4_idle_puf_reset", puf_reset, 1'b1);
        seen = 0;
        for (int i = 0; i < 160; i++) begin
            step();
            if (resp_valid) seen++;
        end
        check("t4_no_resp", seen, 0);
        // abort held during an IDLE start must not block acceptance
        set_const(6'h3F);
        exp_q.push_back({1'b0, 6'b000000, 6'h3F});
        abort = 1'b1;
        issue(32'h4444_0002, '0);
        abort = 1'b0;
        check("t4b_accepted_with_abort", busy, 1'b1);
        wait_resp(LAT, "t4b_latency");
        step();

        // T5: asynchronous reset during FIRE
        set_const(6'h15);
        issue(32'h5555_0001, '1);
        repeat (10) step();
        check("t5_in_fire", puf_trigger, 1'b1);
        #3 reset = 1'b0;
        #1;
        check("t5_async_trigger", puf_trigger, 1'b0);
        check("t5_async_puf_reset", puf_reset, 1'b1);
        check("t5_async_ready", start_ready, 1'b1);
        check("t5_async_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        step();
        check("t5_ready", start_ready, 1'b1);
        check("t5_resp_valid", resp_valid, 1'b0);
        check("t5_resp_data", resp_data, 6'h00);
        check("t5_resp_xor", resp_xor, 1'b0);
        check("t5_resp_unstable", resp_unstable, 6'h00);
        check("t5_challenge", puf_challenge, 32'h0);

        // T6: minimal configuration N=1, R=1, S=1
        s_exp_q.push_back({1'b1, 6'b000000, 6'b000111});
        s_start_valid = 1'b1;
        step();
        s_start_valid = 1'b0;
        check("t6_arm_trigger", s_puf_trigger, 1'b0);
        check("t6_arm_puf_reset", s_puf_reset, 1'b1);
        step();
        check("t6_fire_trigger", s_puf_trigger, 1'b1);
        check("t6_fire_puf_reset", s_puf_reset, 1'b0);
        step();
        check("t6_sample_trigger", s_puf_trigger, 1'b1);
        check("t6_sample_valid", s_resp_valid, 1'b0);
        step();
        check("t6_done_trigger", s_puf_trigger, 1'b0);
        check("t6_done_valid", s_resp_valid, 1'b1);
        step();
        check("t6_back_idle", s_start_ready, 1'b1);

        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 0);
        check("s_scoreboard_empty", s_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
